// File: rtl/key_led_pkg.sv
// key_led_pkg: shared definitions for the key/LED peripheral.
//   - LED mode encodings (2 bits per channel)
//   - clog2_w(): counter width helper, minimum 1 bit
//   - led_sel(): per-channel LED drive selection from mode and shared sources
package key_led_pkg;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_ON    = 2'b01;
  localparam logic [1:0] LED_BLINK = 2'b10;
  localparam logic [1:0] LED_PWM   = 2'b11;

  // Bits needed to hold the values 0..value-1 (at least 1).
  function automatic int clog2_w(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  function automatic logic led_sel(input logic [1:0] mode,
                                   input logic       phase,
                                   input logic       pwm_on);
    logic lit;
    case (mode)
      LED_OFF:   lit = 1'b0;
      LED_ON:    lit = 1'b1;
      LED_BLINK: lit = phase;
      default:   lit = pwm_on;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/key_led_io_debounce.sv
// key_debounce: one key channel.
//   2-flop synchroniser, debounce counter, registered press/release pulses.
//   Optional auto-repeat (macro KEY_LED_AUTOREPEAT_EN): extra press pulses
//   while the debounced key stays held.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_in       raw key pin, 0 = pressed
//   key_level    debounced level, 0 = pressed
//   key_press    1-cycle pulse on debounced press (and on each repeat)
//   key_release  1-cycle pulse on debounced release
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DB_CYCLES     = 2000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int              CW      = clog2_w(DB_CYCLES);
  localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_reg, sync2_reg;
  logic          level_reg, press_reg, release_reg;
  logic [CW-1:0] cnt_reg;
  logic          accept;
  logic          repeat_fire;

  // The synchronised input has differed from the level for DB_CYCLES cycles.
  assign accept = (sync2_reg != level_reg) && (cnt_reg == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      level_reg   <= 1'b1;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg || cnt_reg == DB_LAST) cnt_reg <= '0;
      else                                              cnt_reg <= cnt_reg + CW'(1);
      if (accept) level_reg <= sync2_reg;
      // Pulses are registered alongside level_reg so they coincide with it.
      press_reg   <= (accept && !sync2_reg) || repeat_fire;
      release_reg <= accept && sync2_reg;
    end
  end

`ifdef KEY_LED_AUTOREPEAT_EN
  localparam int            HW = clog2_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_reg;
  logic          first_done_reg;
  logic [HW-1:0] hold_target;

  assign hold_target = first_done_reg ? PERIOD_LAST : DELAY_LAST;
  // While held, accept can only mean a release, which suppresses a repeat.
  assign repeat_fire = !level_reg && !accept && (hold_reg == hold_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg       <= '0;
      first_done_reg <= 1'b0;
    end else if (level_reg || accept) begin
      hold_reg       <= '0;
      first_done_reg <= 1'b0;
    end else if (hold_reg == hold_target) begin
      hold_reg       <= '0;
      first_done_reg <= 1'b1;
    end else begin
      hold_reg <= hold_reg + HW'(1);
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

endmodule

// File: rtl/key_led_io.sv
// key_led_io: N-channel key/LED peripheral.
//   Keys: per-channel debounce (key_debounce), sticky press flags.
//   LEDs: off / on / blink / PWM per channel, registered output.
//   Optional auto-repeat of key presses: define KEY_LED_AUTOREPEAT_EN.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   key_in        raw key pins (0 = pressed)
//   key_level     debounced levels (0 = pressed)
//   key_press     1-cycle press pulses; key_release  1-cycle release pulses
//   evt_pending   sticky press flags; evt_clr  per-bit clear (set wins)
//   led_mode      2 bits per channel: 00 off, 01 on, 10 blink, 11 PWM
//   led_duty      shared PWM duty, applied at the PWM counter wrap
//   led_out       LED drive, 1 = lit
module key_led_io
  import key_led_pkg::*;
#(
  parameter int N_CH          = 8,
  parameter int DB_CYCLES     = 2000000,
  parameter int BLINK_HALF    = 25000000,
  parameter int PWM_BITS      = 8,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     key_in,
  output logic [N_CH-1:0]     key_level,
  output logic [N_CH-1:0]     key_press,
  output logic [N_CH-1:0]     key_release,
  output logic [N_CH-1:0]     evt_pending,
  input  logic [N_CH-1:0]     evt_clr,
  input  logic [2*N_CH-1:0]   led_mode,
  input  logic [PWM_BITS-1:0] led_duty,
  output logic [N_CH-1:0]     led_out
);

  localparam int            BW         = clog2_w(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0]       blink_cnt_reg;
  logic                blink_phase_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PWM_BITS-1:0] duty_shadow_reg;
  logic                pwm_on;
  logic [N_CH-1:0]     evt_reg;
  logic [N_CH-1:0]     led_out_reg;
  logic [N_CH-1:0]     led_next;

  assign pwm_on = pwm_cnt_reg < duty_shadow_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    key_debounce #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_db (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[gi]),
      .key_level  (key_level[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi])
    );
    assign led_next[gi] = led_sel(led_mode[2*gi +: 2], blink_phase_reg, pwm_on);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      pwm_cnt_reg     <= '0;
      duty_shadow_reg <= '0;
      evt_reg         <= '0;
      led_out_reg     <= '0;
    end else begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BW'(1);
      end
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      // Load the duty as the counter wraps so each period uses one duty value.
      if (pwm_cnt_reg == '1) duty_shadow_reg <= led_duty;
      evt_reg     <= (evt_reg & ~evt_clr) | key_press;
      led_out_reg <= led_next;
    end
  end

  assign evt_pending = evt_reg;
  assign led_out     = led_out_reg;

endmodule

// File: tb/tb_key_led_io.sv
module tb_key_led_io;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] evt_pending;
  logic [3:0] evt_clr;
  logic [7:0] led_mode;
  logic [3:0] led_duty;
  logic [3:0] led_out;

  int errors = 0;
  int checks = 0;

  key_led_io #(
    .N_CH(4), .DB_CYCLES(16), .BLINK_HALF(8), .PWM_BITS(4),
    .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release),
    .evt_pending(evt_pending), .evt_clr(evt_clr),
    .led_mode(led_mode), .led_duty(led_duty), .led_out(led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_in = 4'hF; evt_clr = 4'h0; led_mode = 8'h00; led_duty = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({key_level, key_press, key_release, evt_pending, led_out} !== 20'hF0000) begin
      errors++;
      $display("FAIL reset_state: got lvl=%h prs=%h rel=%h evt=%h led=%h, want F/0/0/0/0",
               key_level, key_press, key_release, evt_pending, led_out);
    end
    #2 rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_press();
    int lvl_t = -1, prs_t = -1, prs_n = 0, rel_n = 0;
    key_in[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (key_level[0] == 1'b0 && lvl_t < 0) lvl_t = k;
      if (key_press[0]) begin prs_n++; prs_t = k; end
      if (key_release[0]) rel_n++;
    end
    checks++;
    if (lvl_t !== 18) begin errors++; $display("FAIL press_latency: got %0d want 18", lvl_t); end
    checks++;
    if (prs_n !== 1 || prs_t !== 18) begin
      errors++; $display("FAIL press_pulse: got count=%0d at=%0d want 1 at 18", prs_n, prs_t);
    end
    checks++;
    if (rel_n !== 0) begin errors++; $display("FAIL press_no_release: got %0d want 0", rel_n); end
    checks++;
    if (evt_pending !== 4'b0001) begin
      errors++; $display("FAIL press_evt: got %b want 0001", evt_pending);
    end
    key_in[0] = 1'b1;
    rel_n = 0; lvl_t = -1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (key_level[0] == 1'b1 && lvl_t < 0) lvl_t = k;
      if (key_release[0]) rel_n++;
    end
    checks++;
    if (lvl_t !== 18 || rel_n !== 1) begin
      errors++; $display("FAIL release: got level_at=%0d pulses=%0d want 18 and 1", lvl_t, rel_n);
    end
    $display("test_press done");
  endtask

  task automatic test_bounce();
    int changes = 0, pulses = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 5 == 0) key_in[1] = (k / 5) % 2 == 1;
      tick();
      if (key_level[1] !== 1'b1) changes++;
      if (key_press[1] || key_release[1]) pulses++;
    end
    key_in[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (key_level[1] !== 1'b1) changes++;
      if (key_press[1] || key_release[1]) pulses++;
    end
    checks++;
    if (changes !== 0 || pulses !== 0) begin
      errors++; $display("FAIL bounce: got level_changes=%0d pulses=%0d want 0 and 0", changes, pulses);
    end
    checks++;
    if (evt_pending[1] !== 1'b0) begin errors++; $display("FAIL bounce_evt: got %b want 0", evt_pending[1]); end
    $display("test_bounce done");
  endtask

  task automatic test_sticky_race();
    int seen = 0;
    evt_clr[0] = 1'b1; tick(); evt_clr[0] = 1'b0;
    checks++;
    if (evt_pending[0] !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b want 0", evt_pending[0]); end
    key_in[0] = 1'b0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      tick();
      if (key_press[0]) seen = 1;
    end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL race_press_seen: got %0d want 1", seen); end
    evt_clr[0] = 1'b1; tick(); evt_clr[0] = 1'b0;
    checks++;
    if (evt_pending[0] !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %b want 1", evt_pending[0]); end
    evt_clr[0] = 1'b1; tick(); evt_clr[0] = 1'b0;
    checks++;
    if (evt_pending[0] !== 1'b0) begin errors++; $display("FAIL clr_after_race: got %b want 0", evt_pending[0]); end
    key_in[0] = 1'b1;
    repeat (25) tick();
    evt_clr = 4'hF; tick(); evt_clr = 4'h0;
    $display("test_sticky_race done");
  endtask

  task automatic test_led_modes();
    logic [31:0] b2, b3;
    int ones3 = 0, ones2 = 0, bad = 0, found = 0;
    logic prev;
    led_mode = 8'b11_10_01_00;
    led_duty = 4'd4;
    repeat (20) tick();
    for (int k = 0; k < 32; k++) begin
      tick();
      b2[k] = led_out[2]; b3[k] = led_out[3];
      if (led_out[0] !== 1'b0 || led_out[1] !== 1'b1) bad++;
      if (b2[k]) ones2++;
      if (b3[k]) ones3++;
    end
    for (int k = 8; k < 32; k++) if (b2[k] == b2[k-8]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL led_static_blink: got %0d bad samples want 0", bad); end
    checks++;
    if (ones2 !== 16) begin errors++; $display("FAIL led_blink_duty: got %0d want 16", ones2); end
    checks++;
    if (ones3 !== 8) begin errors++; $display("FAIL led_pwm4: got %0d lit of 32 want 8", ones3); end
    // Find the sample that reflects PWM counter 0 (rising edge of ch3).
    prev = led_out[3];
    for (int k = 0; k < 40 && found == 0; k++) begin
      tick();
      if (!prev && led_out[3]) found = 1;
      prev = led_out[3];
    end
    checks++;
    if (found !== 1) begin errors++; $display("FAIL pwm_wrap_seen: got %0d want 1", found); end
    tick(); tick();
    led_duty = 4'd12;
    ones3 = 0;
    for (int k = 0; k < 13; k++) begin tick(); if (led_out[3]) ones3++; end
    checks++;
    if (ones3 !== 1) begin errors++; $display("FAIL duty_mid_period: got %0d lit want 1", ones3); end
    ones3 = 0;
    for (int k = 0; k < 16; k++) begin tick(); if (led_out[3]) ones3++; end
    checks++;
    if (ones3 !== 12) begin errors++; $display("FAIL duty_after_wrap: got %0d lit want 12", ones3); end
    led_mode = 8'b11_10_01_01;
    tick();
    checks++;
    if (led_out[1:0] !== 2'b11) begin errors++; $display("FAIL mode_ch0_on: got %b want 11", led_out[1:0]); end
    led_mode = 8'b11_10_00_01;
    tick();
    checks++;
    if (led_out[1:0] !== 2'b01) begin errors++; $display("FAIL mode_ch1_off: got %b want 01", led_out[1:0]); end
    led_mode = 8'b11_10_01_00;
    $display("test_led_modes done");
  endtask

  // Leaves key 2 held with its debounced press just observed.
  task automatic test_async_reset();
    int prs_t = -1;
    repeat (3) tick();
    key_in[2] = 1'b0;
    repeat (5) tick();
    checks++;
    if (led_out[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_led: got %b want 1", led_out[1]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release, evt_pending, led_out} !== 20'hF0000) begin
      errors++;
      $display("FAIL async_reset: got lvl=%h prs=%h rel=%h evt=%h led=%h, want F/0/0/0/0",
               key_level, key_press, key_release, evt_pending, led_out);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 30 && prs_t < 0; k++) begin
      tick();
      if (key_press[2]) prs_t = k;
    end
    checks++;
    if (prs_t !== 18 || key_level[2] !== 1'b0) begin
      errors++; $display("FAIL held_through_reset: got press_at=%0d level=%b want 18 and 0", prs_t, key_level[2]);
    end
    checks++;
    if (led_out[1:0] !== 2'b10) begin errors++; $display("FAIL post_reset_led: got %b want 10", led_out[1:0]); end
    $display("test_async_reset done");
  endtask

  task automatic test_autorepeat();
    int offs[$];
    int got_rel = 0, late = 0;
    for (int k = 1; k <= 95; k++) begin
      tick();
      if (key_press[2]) offs.push_back(k);
      if (k == 41) evt_clr[2] = 1'b1;
      if (k == 42) evt_clr[2] = 1'b0;
      if (k == 43) begin
        checks++;
        if (evt_pending[2] !== 1'b0) begin errors++; $display("FAIL repeat_evt_clr: got %b want 0", evt_pending[2]); end
      end
      if (k == 51) begin
        checks++;
`ifdef KEY_LED_AUTOREPEAT_EN
        if (evt_pending[2] !== 1'b1) begin errors++; $display("FAIL repeat_evt_set: got %b want 1", evt_pending[2]); end
`else
        if (evt_pending[2] !== 1'b0) begin errors++; $display("FAIL no_repeat_evt: got %b want 0", evt_pending[2]); end
`endif
      end
    end
    checks++;
`ifdef KEY_LED_AUTOREPEAT_EN
    if (offs.size() !== 6 || offs[0] != 40 || offs[1] != 50 || offs[2] != 60 ||
        offs[3] != 70 || offs[4] != 80 || offs[5] != 90) begin
      errors++; $display("FAIL repeat_offsets: got %0d pulses (%p) want 40,50,60,70,80,90", offs.size(), offs);
    end
`else
    if (offs.size() !== 0) begin
      errors++; $display("FAIL single_press: got %0d extra pulses want 0", offs.size());
    end
`endif
    key_in[2] = 1'b1;
    for (int k = 0; k < 40 && got_rel == 0; k++) begin
      tick();
      if (key_release[2]) got_rel = 1;
    end
    checks++;
    if (got_rel !== 1) begin errors++; $display("FAIL hold_release: got %0d want 1", got_rel); end
    for (int k = 0; k < 60; k++) begin tick(); if (key_press[2]) late++; end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL press_after_release: got %0d want 0", late); end
    $display("test_autorepeat done");
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_sticky_race();
    test_led_modes();
    test_async_reset();
    test_autorepeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
